// File: rtl/mem_pkg.sv
// Shared encodings for the data memory unit.
// Access sizes and the controller state enum.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/load_align.sv
// Load lane extraction and sign/zero extension.
// Purely combinational; picks the addressed lane of a word.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = word[8*offset +: 8];
    h    = offset[1] ? word[31:16] : word[15:0];
    data = '0;
    unique case (1'b1)
      (size == SZ_BYTE): data = uns ? {24'd0, b}
                                    : {{24{b[7]}}, b};
      (size == SZ_HALF): data = uns ? {16'd0, h}
                                    : {{16{h[15]}}, h};
      (size == SZ_WORD): data = word;
      default:           data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Byte-addressed little-endian data memory with
// zero-fill after reset and one-cycle load latency.
module data_mem_unit
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES    = 4096,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic        rsp_valid,
  output logic [31:0] readData,
  output logic        access_err,
  output logic        busy
);

  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int IW    = AW - 2;
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_e      state;
  logic [IW-1:0] clr_idx;
  logic [31:0] mem [WORDS];

  logic          accept;
  logic          fault;
  logic          misalign;
  logic          in_range;
  logic [IW-1:0] widx;
  logic [1:0]    off;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   ld_data;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state == ST_CLEAR);
  assign accept    = req_valid && req_ready;
  assign widx      = address[AW-1:2];
  assign off       = address[1:0];
  assign in_range  = ((address >> AW) == 32'd0);

  always_comb begin
    misalign = 1'b0;
    unique case (1'b1)
      (req_size == SZ_HALF): misalign = off[0];
      (req_size == SZ_WORD): misalign = (off != 2'b00);
      (req_size == SZ_BAD):  misalign = 1'b1;
      default:               misalign = 1'b0;
    endcase
    fault = misalign || !in_range;
  end

  // Replicate store data so every lane carries it; be picks lanes.
  always_comb begin
    be    = 4'b0000;
    wlane = writeData;
    unique case (1'b1)
      (req_size == SZ_BYTE): begin
        be    = 4'b0001 << off;
        wlane = {4{writeData[7:0]}};
      end
      (req_size == SZ_HALF): begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wlane = {2{writeData[15:0]}};
      end
      (req_size == SZ_WORD): begin
        be    = 4'b1111;
        wlane = writeData;
      end
      default: begin
        be    = 4'b0000;
        wlane = writeData;
      end
    endcase
  end

  load_align u_align (
    .word   (mem[widx]),
    .offset (off),
    .size   (req_size),
    .uns    (req_unsigned),
    .data   (ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_idx <= '0;
    end else if (state == ST_CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == LAST) begin
        state <= ST_IDLE;
      end
    end
  end

  // Storage is zeroed only by the clear walk, never by reset.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (accept && req_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[widx][8*i +: 8] <= wlane[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      access_err <= 1'b0;
      readData   <= '0;
    end else begin
      rsp_valid  <= accept;
      access_err <= accept && fault;
      readData   <= (accept && !fault && !req_we) ? ld_data : '0;
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit (64-byte instance)
// against a byte-array reference model.
module tb_data_mem_unit;

  localparam int DB = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        rsp_valid;
  logic [31:0] readData;
  logic        access_err;
  logic        busy;

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] ref_mem [DB];
  int         total = 0;
  int         bad   = 0;
  int         nreq  = 0;

  always #5 clk = ~clk;

  data_mem_unit #(.DEPTH_BYTES(DB), .CLEAR_ON_RESET(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .address      (address),
    .writeData    (writeData),
    .rsp_valid    (rsp_valid),
    .readData     (readData),
    .access_err   (access_err),
    .busy         (busy)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp got=1 exp=0");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check($sformatf("rsp%0d_err", e.id), {31'd0, access_err},
              {31'd0, e.err});
        check($sformatf("rsp%0d_data", e.id), readData, e.data);
      end
    end
  end

  function automatic logic is_fault(input logic [1:0] sz,
                                    input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
           (sz == 2'b10 && a[1:0] != 2'b00) || (a >= DB);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz,
                                             input logic uns,
                                             input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    v = 0;
    for (int i = 0; i < n; i++) v |= 32'(ref_mem[a + i]) << (8 * i);
    if (!uns && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
    return v;
  endfunction

  task automatic issue(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a,
                       input logic [31:0] wd);
    exp_t e;
    @(negedge clk);
    check("ready_at_issue", {31'd0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    address      = a;
    writeData    = wd;
    e.id   = nreq++;
    e.err  = is_fault(sz, a);
    e.data = 0;
    if (!e.err && !we) e.data = model_load(sz, uns, a);
    if (!e.err && we) begin
      for (int i = 0; i < nbytes(sz); i++)
        ref_mem[a + i] = wd[8*i +: 8];
    end
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic count_clear(input string nm);
    int cnt;
    int nrdy;
    cnt  = 0;
    nrdy = 0;
    while (busy && cnt < 100) begin
      if (req_ready) nrdy++;
      cnt++;
      @(negedge clk);
    end
    check({nm, "_busy_cycles"}, cnt, 16);
    check({nm, "_ready_in_clear"}, nrdy, 0);
    check({nm, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < DB; i++) ref_mem[i] = 8'h00;
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    address      = 0;
    writeData    = 0;
    for (int i = 0; i < DB; i++) ref_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_readData", readData, 32'd0);
    reset = 1'b0;
    count_clear("clr1");

    issue(1'b0, 2'b10, 1'b0, 32'h3C, 0);
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 0);
    issue(1'b0, 2'b00, 1'b1, 32'h11, 0);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 0);
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000007F);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 0);
    issue(1'b0, 2'b01, 1'b0, 32'h05, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h06, 0);
    issue(1'b0, 2'b11, 1'b0, 32'h00, 0);
    issue(1'b0, 2'b10, 1'b0, DB, 0);
    issue(1'b1, 2'b10, 1'b0, 32'h06, 32'hFFFFFFFF);
    issue(1'b1, 2'b10, 1'b0, DB + 32'h10, 32'h12345678);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h04, 0);
    issue(1'b1, 2'b10, 1'b0, 32'h08, 32'hA5A5A5A5);
    issue(1'b0, 2'b10, 1'b0, 32'h08, 0);
    idle(3);
    check("spec_vectors_drained", sbq.size(), 0);

    for (int k = 0; k < 300; k++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = $urandom_range(0, DB + 7);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      issue($urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1,
            a, $urandom);
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    idle(4);
    check("random_drained", sbq.size(), 0);

    // Reset mid-clear at clear cycle 5.
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("midclr_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    idle(2);
    check("midclr_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    count_clear("clr2");

    // In-flight response is discarded by reset.
    issue(1'b0, 2'b10, 1'b0, 32'h00, 0);
    void'(sbq.pop_back());
    @(posedge clk);
    #1 reset = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check("inflight_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b0;
    count_clear("clr3");
    issue(1'b0, 2'b10, 1'b0, 32'h08, 0);
    idle(3);
    check("final_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 4096, byte capacity, power of two, >= 8.
REQ-002 SHALL have parameter CLEAR_ON_RESET, default 1, 1 = zero-fill all storage after reset.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port address  input  32  byte address.
REQ-011 SHALL have port writeData  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-013 SHALL have port readData  output  32  load result, extended to 32 bits.
REQ-014 SHALL have port access_err  output  1  valid with rsp_valid; request faulted.
REQ-015 SHALL have port busy  output  1  high while clear sequence runs.

Function
REQ-016 Storage SHALL be little-endian, byte-addressed, organised as DEPTH_BYTES/4 words with per-byte write enables; word index = address[log2(DEPTH_BYTES)-1:2].
REQ-017 FSM states SHALL be CLEAR and IDLE; reset enters CLEAR if CLEAR_ON_RESET=1, else IDLE.
REQ-018 CLEAR SHALL write zero to one word per cycle from index 0 upward; after the last index (DEPTH_BYTES/4 cycles), CLEAR -> IDLE.
REQ-019 req_ready SHALL be 0 and busy 1 in CLEAR; req_ready 1 and busy 0 in IDLE.
REQ-020 Accepted request SHALL fault when: req_size=11; half with address[0]=1; word with address[1:0]!=00; or address >= DEPTH_BYTES.
REQ-021 Faulted request SHALL not modify storage; response: rsp_valid=1, access_err=1, readData=0.
REQ-022 Accepted non-faulted store SHALL update only the addressed byte lanes at the accepting edge; response next cycle with access_err=0, readData=0.
REQ-023 Accepted non-faulted load SHALL produce rsp_valid=1, readData=extended data exactly one cycle after acceptance (latency 1).
REQ-024 Throughput SHALL be one request per cycle; back-to-back requests yield back-to-back rsp_valid pulses.
REQ-025 Load accepted the cycle after a store to the same bytes SHALL return the stored value.
REQ-026 rsp_valid SHALL be 0 in any cycle not immediately following an acceptance.
REQ-027 address bits above log2(DEPTH_BYTES)-1 SHALL only be used for the range check.

Reset
REQ-028 Reset SHALL asynchronously force rsp_valid=0, access_err=0, readData=0, clear index=0, state per REQ-017.
REQ-029 Reset asserted mid-CLEAR or mid-traffic SHALL abort; clear restarts from index 0 after deassertion; in-flight response discarded.
REQ-030 Storage array SHALL not be reset directly; zeroing is only via CLEAR.

Structure
REQ-031 Shared package mem_pkg SHALL hold size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-032 Lane extraction and sign/zero extension SHALL live in combinational sub-module load_align (inputs word, offset, size, unsigned; output 32-bit).
REQ-033 Store lane replication and byte-enable generation SHALL reside in data_mem_unit.

Verification
REQ-034 Reset, DEPTH_BYTES=64: busy=1, req_ready=0 for exactly 16 cycles, then busy=0; load word @0x3C -> 0x00000000.
REQ-035 Store word 0xDEADBEEF @0x10; load byte signed @0x13 -> 0xFFFFFFDE; byte unsigned @0x11 -> 0x000000BE; half signed @0x12 -> 0xFFFFDEAD.
REQ-036 Store byte 0x7F @0x21 over word 0x11223344 @0x20; load word @0x20 -> 0x11227F44.
REQ-037 Load half @0x05, word @0x06, size 11 @0x00, word @DEPTH_BYTES -> each access_err=1, readData=0; prior contents unchanged.
REQ-038 Back-to-back store word 0xA5A5A5A5 @0x08 then load word @0x08 on consecutive cycles -> two consecutive rsp_valid pulses, second readData=0xA5A5A5A5.
REQ-039 Assert reset at clear cycle 5 for 2 cycles -> busy restarts, full 16-cycle clear repeats, rsp_valid stays 0 throughout.
